// File: rtl/dlx_pipe_ctrl_if.sv
// Shared DLX pipe-control types and the bundle between the pipe datapath and dlx_pipe_ctrl.
// The datapath side uses the master modport; the controller uses the slave modport.
package dlx_pipe_pkg;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    RR_ALU = 3'd1,
    IM_ALU = 3'd2,
    LOAD   = 3'd3,
    STORE  = 3'd4,
    BRANCH = 3'd5,
    JUMP   = 3'd6,
    TRAP   = 3'd7
  } opcode_class_e;

  typedef logic [4:0] reg_adr_t;

  typedef enum logic {
    FWDSEL_ID_A           = 1'b0,
    FWDSEL_EX_MEM_ALU_OUT = 1'b1
  } fwd_select_e;

endpackage

interface dlx_pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import dlx_pipe_pkg::*;

  logic             dc_wait;
  opcode_class_e    id_opcode_class;
  reg_adr_t         id_ir_rs1;
  reg_adr_t         id_ir_rs2;
  logic             id_cond;
  logic             id_halt;
  logic             id_illegal_instr;
  opcode_class_e    id_ex_opcode_class;
  reg_adr_t         id_ex_reg_rd;
  logic             id_ex_reg_wen;
  opcode_class_e    ex_mem_opcode_class;
  reg_adr_t         ex_mem_reg_rd;
  logic             ex_mem_reg_wen;

  logic             stall;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             pipe_freeze;
  fwd_select_e      id_a_fwd_sel;
  logic             halted;
  logic             illegal_trap;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output dc_wait, id_opcode_class, id_ir_rs1, id_ir_rs2, id_cond, id_halt, id_illegal_instr,
           id_ex_opcode_class, id_ex_reg_rd, id_ex_reg_wen,
           ex_mem_opcode_class, ex_mem_reg_rd, ex_mem_reg_wen,
    input  stall, id_ex_bubble, if_id_flush, pipe_freeze, id_a_fwd_sel,
           halted, illegal_trap, cycle_cnt, stall_cnt
  );

  modport slave (
    input  dc_wait, id_opcode_class, id_ir_rs1, id_ir_rs2, id_cond, id_halt, id_illegal_instr,
           id_ex_opcode_class, id_ex_reg_rd, id_ex_reg_wen,
           ex_mem_opcode_class, ex_mem_reg_rd, ex_mem_reg_wen,
    output stall, id_ex_bubble, if_id_flush, pipe_freeze, id_a_fwd_sel,
           halted, illegal_trap, cycle_cnt, stall_cnt
  );

endinterface

// File: rtl/dlx_pipe_ctrl.sv
// DLX pipeline sequencer: load/branch hazard stalls, ID operand-A forwarding, taken-branch
// flush, TRAP/illegal drain-and-halt, data-cache freeze, and cycle/stall counters.
module dlx_pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input logic            clk,
  input logic            rst,
  dlx_pipe_ctrl_if.slave bus
);
  import dlx_pipe_pkg::*;

  typedef enum logic [1:0] {StRun, StDcWait, StDrain, StHalted} state_e;

  localparam logic [2:0] DrainInit = 3'(DRAIN_CYCLES);

  state_e           state_q, state_d, eff_state;
  logic             ret_drain_q, ret_drain_d;
  logic [2:0]       drain_q, drain_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q;

  logic        stall, bubble, flush, freeze;
  fwd_select_e fwd_sel;

  logic uses_rs1, uses_rs2, rs1_nz;
  logic ex_ld, br_ex, br_mem_ld, hazard, fwd_hit;

  always_comb begin
    uses_rs1 = bus.id_opcode_class inside {RR_ALU, IM_ALU, LOAD, STORE, BRANCH};
    uses_rs2 = bus.id_opcode_class inside {RR_ALU, STORE};
    rs1_nz   = bus.id_ir_rs1 != '0;

    ex_ld = (bus.id_ex_opcode_class == LOAD) && bus.id_ex_reg_wen &&
            ((uses_rs1 && rs1_nz && (bus.id_ex_reg_rd == bus.id_ir_rs1)) ||
             (uses_rs2 && (bus.id_ir_rs2 != '0) && (bus.id_ex_reg_rd == bus.id_ir_rs2)));
    // Branch compares in ID, so an EX producer can never reach it in time.
    br_ex = (bus.id_opcode_class == BRANCH) && bus.id_ex_reg_wen && rs1_nz &&
            (bus.id_ex_reg_rd == bus.id_ir_rs1);
    br_mem_ld = (bus.id_opcode_class == BRANCH) && (bus.ex_mem_opcode_class == LOAD) &&
                bus.ex_mem_reg_wen && rs1_nz && (bus.ex_mem_reg_rd == bus.id_ir_rs1);
    hazard = ex_ld | br_ex | br_mem_ld;

    fwd_hit = bus.ex_mem_reg_wen && rs1_nz && (bus.ex_mem_reg_rd == bus.id_ir_rs1) &&
              (bus.ex_mem_opcode_class inside {RR_ALU, IM_ALU});
  end

  always_comb begin
    // Once dc_wait drops, DCWAIT behaves as the state it interrupted in that same cycle.
    eff_state = state_q;
    if (state_q == StDcWait) eff_state = ret_drain_q ? StDrain : StRun;

    state_d     = state_q;
    ret_drain_d = ret_drain_q;
    drain_d     = drain_q;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    stall       = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    freeze      = 1'b0;
    fwd_sel     = FWDSEL_ID_A;

    case (eff_state)
      StHalted: begin
        stall  = 1'b1;
        freeze = 1'b1;
        bubble = 1'b1;
      end
      StRun, StDrain: begin
        if (bus.dc_wait) begin
          stall       = 1'b1;
          freeze      = 1'b1;
          state_d     = StDcWait;
          ret_drain_d = (eff_state == StDrain);
        end else if (eff_state == StDrain) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          flush   = 1'b1;
          state_d = StDrain;
          if (drain_q <= 3'd1) begin
            drain_d  = '0;
            state_d  = StHalted;
            halted_d = 1'b1;
          end else begin
            drain_d = drain_q - 3'd1;
          end
        end else begin
          state_d = StRun;
          fwd_sel = fwd_hit ? FWDSEL_EX_MEM_ALU_OUT : FWDSEL_ID_A;
          if (hazard) begin
            stall  = 1'b1;
            bubble = 1'b1;
          end else if (bus.id_halt || bus.id_illegal_instr) begin
            bubble    = 1'b1;
            illegal_d = bus.id_illegal_instr;
            drain_d   = DrainInit;
            state_d   = StDrain;
          end else if (bus.id_cond) begin
            flush = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      ret_drain_q <= 1'b0;
      drain_q     <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_drain_q <= ret_drain_d;
      drain_q     <= drain_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      if (state_q != StHalted) begin
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
        if (stall || freeze) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall        = stall;
  assign bus.id_ex_bubble = bubble;
  assign bus.if_id_flush  = flush;
  assign bus.pipe_freeze  = freeze;
  assign bus.id_a_fwd_sel = fwd_sel;
  assign bus.halted       = halted_q;
  assign bus.illegal_trap = illegal_q;
  assign bus.cycle_cnt    = cycle_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// Bench for dlx_pipe_ctrl: reset-held vector table, directed hazard/halt/cache-wait
// sequences and a random stream, all checked against a cycle-level reference model.
module tb_dlx_pipe_ctrl;
  import dlx_pipe_pkg::*;

  localparam int unsigned DRAIN = 3;
  localparam int unsigned CW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dlx_pipe_ctrl_if #(.CNT_W(CW)) bus ();
  dlx_pipe_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic          rst, dc_wait, cond, halt, ill;
    opcode_class_e id_cls, ex_cls, mem_cls;
    reg_adr_t      rs1, rs2, ex_rd, mem_rd;
    logic          ex_wen, mem_wen;
  } stim_t;

  typedef struct {
    logic        stall, bubble, flush, freeze;
    fwd_select_e fwd;
  } ctl_t;

  typedef struct {
    string name;
    stim_t in;
    ctl_t  exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Reference model state: remaining drain cycles (0 = not draining), halted/illegal flags.
  int          m_drain;
  bit          m_halted, m_illegal;
  logic [31:0] m_cycles, m_stalls;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic stim_t st(opcode_class_e idc, int r1, int r2, bit cond, bit halt, bit ill,
                               opcode_class_e exc, int exrd, bit exw,
                               opcode_class_e mc, int mrd, bit mw);
    stim_t s;
    s.rst = 1'b0; s.dc_wait = 1'b0;
    s.id_cls = idc; s.rs1 = reg_adr_t'(r1); s.rs2 = reg_adr_t'(r2);
    s.cond = cond; s.halt = halt; s.ill = ill;
    s.ex_cls = exc; s.ex_rd = reg_adr_t'(exrd); s.ex_wen = exw;
    s.mem_cls = mc; s.mem_rd = reg_adr_t'(mrd); s.mem_wen = mw;
    return s;
  endfunction

  function automatic stim_t nop_s();
    return st(NOP, 0, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 0);
  endfunction

  function automatic ctl_t ctl(bit s, bit b, bit f, bit z, fwd_select_e w);
    ctl_t c;
    c.stall = s; c.bubble = b; c.flush = f; c.freeze = z; c.fwd = w;
    return c;
  endfunction

  function automatic bit tb_hazard(stim_t s);
    bit r1 = s.id_cls inside {RR_ALU, IM_ALU, LOAD, STORE, BRANCH};
    bit r2 = s.id_cls inside {RR_ALU, STORE};
    bit ld_use = (s.ex_cls == LOAD) && s.ex_wen &&
                 ((r1 && s.rs1 != 0 && s.ex_rd == s.rs1) || (r2 && s.rs2 != 0 && s.ex_rd == s.rs2));
    bit br1 = (s.id_cls == BRANCH) && s.ex_wen && s.rs1 != 0 && s.ex_rd == s.rs1;
    bit br2 = (s.id_cls == BRANCH) && (s.mem_cls == LOAD) && s.mem_wen && s.rs1 != 0 &&
              s.mem_rd == s.rs1;
    return ld_use || br1 || br2;
  endfunction

  function automatic ctl_t model_comb(stim_t s);
    ctl_t e = ctl(0, 0, 0, 0, FWDSEL_ID_A);
    if (m_halted) e = ctl(1, 1, 0, 1, FWDSEL_ID_A);
    else if (s.dc_wait) e = ctl(1, 0, 0, 1, FWDSEL_ID_A);
    else if (m_drain > 0) e = ctl(1, 1, 1, 0, FWDSEL_ID_A);
    else begin
      if (s.mem_wen && s.rs1 != 0 && s.mem_rd == s.rs1 && s.mem_cls inside {RR_ALU, IM_ALU})
        e.fwd = FWDSEL_EX_MEM_ALU_OUT;
      if (tb_hazard(s)) begin e.stall = 1; e.bubble = 1; end
      else if (s.halt || s.ill) e.bubble = 1;
      else if (s.cond) e.flush = 1;
    end
    return e;
  endfunction

  task automatic model_commit(stim_t s, ctl_t e);
    if (s.rst) begin
      m_drain = 0; m_halted = 0; m_illegal = 0; m_cycles = 0; m_stalls = 0;
      return;
    end
    if (!m_halted) begin
      m_cycles++;
      if (e.stall || e.freeze) m_stalls++;
    end
    if (m_halted || s.dc_wait) return;
    if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) m_halted = 1;
    end else if (!tb_hazard(s) && (s.halt || s.ill)) begin
      m_drain   = DRAIN;
      m_illegal = s.ill;
    end
  endtask

  task automatic apply(stim_t s);
    rst                     = s.rst;
    bus.dc_wait             = s.dc_wait;
    bus.id_opcode_class     = s.id_cls;
    bus.id_ir_rs1           = s.rs1;
    bus.id_ir_rs2           = s.rs2;
    bus.id_cond             = s.cond;
    bus.id_halt             = s.halt;
    bus.id_illegal_instr    = s.ill;
    bus.id_ex_opcode_class  = s.ex_cls;
    bus.id_ex_reg_rd        = s.ex_rd;
    bus.id_ex_reg_wen       = s.ex_wen;
    bus.ex_mem_opcode_class = s.mem_cls;
    bus.ex_mem_reg_rd       = s.mem_rd;
    bus.ex_mem_reg_wen      = s.mem_wen;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic do_cycle(stim_t s, string tag);
    ctl_t e;
    apply(s);
    #3;
    e = model_comb(s);
    chk({tag, ".stall"},  32'(bus.stall),        32'(e.stall));
    chk({tag, ".bubble"}, 32'(bus.id_ex_bubble), 32'(e.bubble));
    chk({tag, ".flush"},  32'(bus.if_id_flush),  32'(e.flush));
    chk({tag, ".freeze"}, 32'(bus.pipe_freeze),  32'(e.freeze));
    chk({tag, ".fwd"},    32'(bus.id_a_fwd_sel), 32'(e.fwd));
    @(posedge clk);
    #1;
    model_commit(s, e);
    chk({tag, ".halted"},  32'(bus.halted),       32'(m_halted));
    chk({tag, ".illegal"}, 32'(bus.illegal_trap), 32'(m_illegal));
    chk({tag, ".cycles"},  bus.cycle_cnt,         m_cycles);
    chk({tag, ".stalls"},  bus.stall_cnt,         m_stalls);
  endtask

  task automatic do_reset();
    stim_t s = nop_s();
    s.rst = 1'b1;
    do_cycle(s, "reset");
  endtask

  // Clock NOPs until halted; returns edges consumed, or -1 if the budget runs out.
  task automatic wait_halt(input int budget, output int edges);
    edges = -1;
    for (int i = 1; i <= budget; i++) begin
      do_cycle(nop_s(), "drain");
      if (bus.halted === 1'b1) begin edges = i; break; end
    end
  endtask

  vec_t        tbl[$];
  stim_t       s;
  int          edges;
  logic [31:0] snap;

  initial begin
    m_drain = 0; m_halted = 0; m_illegal = 0; m_cycles = 0; m_stalls = 0;
    apply(nop_s());
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    tbl.push_back('{"nop", nop_s(), ctl(0, 0, 0, 0, FWDSEL_ID_A)});
    tbl.push_back('{"lduse_rs1", st(RR_ALU, 3, 5, 0, 0, 0, LOAD, 3, 1, NOP, 0, 0),
                    ctl(1, 1, 0, 0, FWDSEL_ID_A)});
    tbl.push_back('{"lduse_rs2", st(RR_ALU, 5, 3, 0, 0, 0, LOAD, 3, 1, NOP, 0, 0),
                    ctl(1, 1, 0, 0, FWDSEL_ID_A)});
    tbl.push_back('{"lduse_imm_rs2", st(IM_ALU, 5, 3, 0, 0, 0, LOAD, 3, 1, NOP, 0, 0),
                    ctl(0, 0, 0, 0, FWDSEL_ID_A)});
    tbl.push_back('{"lduse_r0", st(RR_ALU, 0, 0, 0, 0, 0, LOAD, 0, 1, NOP, 0, 0),
                    ctl(0, 0, 0, 0, FWDSEL_ID_A)});
    tbl.push_back('{"lduse_nowen", st(RR_ALU, 3, 5, 0, 0, 0, LOAD, 3, 0, NOP, 0, 0),
                    ctl(0, 0, 0, 0, FWDSEL_ID_A)});
    tbl.push_back('{"alu_in_ex", st(RR_ALU, 3, 5, 0, 0, 0, RR_ALU, 3, 1, NOP, 0, 0),
                    ctl(0, 0, 0, 0, FWDSEL_ID_A)});
    tbl.push_back('{"br_ex", st(BRANCH, 2, 0, 1, 0, 0, IM_ALU, 2, 1, NOP, 0, 0),
                    ctl(1, 1, 0, 0, FWDSEL_ID_A)});
    tbl.push_back('{"br_mem_ld", st(BRANCH, 2, 0, 1, 0, 0, NOP, 0, 0, LOAD, 2, 1),
                    ctl(1, 1, 0, 0, FWDSEL_ID_A)});
    tbl.push_back('{"br_fwd", st(BRANCH, 2, 0, 1, 0, 0, NOP, 0, 0, IM_ALU, 2, 1),
                    ctl(0, 0, 1, 0, FWDSEL_EX_MEM_ALU_OUT)});
    tbl.push_back('{"rr_fwd", st(RR_ALU, 2, 7, 0, 0, 0, NOP, 0, 0, RR_ALU, 2, 1),
                    ctl(0, 0, 0, 0, FWDSEL_EX_MEM_ALU_OUT)});
    tbl.push_back('{"mem_ld_nofwd", st(RR_ALU, 2, 7, 0, 0, 0, NOP, 0, 0, LOAD, 2, 1),
                    ctl(0, 0, 0, 0, FWDSEL_ID_A)});
    tbl.push_back('{"fwd_r0", st(RR_ALU, 0, 7, 0, 0, 0, NOP, 0, 0, RR_ALU, 0, 1),
                    ctl(0, 0, 0, 0, FWDSEL_ID_A)});
    tbl.push_back('{"cond_vs_ld", st(RR_ALU, 3, 5, 1, 0, 0, LOAD, 3, 1, NOP, 0, 0),
                    ctl(1, 1, 0, 0, FWDSEL_ID_A)});
    tbl.push_back('{"cond_only", st(JUMP, 3, 0, 1, 0, 0, LOAD, 3, 1, NOP, 0, 0),
                    ctl(0, 0, 1, 0, FWDSEL_ID_A)});
    tbl.push_back('{"halt_vs_hz", st(RR_ALU, 3, 5, 0, 1, 0, LOAD, 3, 1, NOP, 0, 0),
                    ctl(1, 1, 0, 0, FWDSEL_ID_A)});
    tbl.push_back('{"halt_accept", st(TRAP, 0, 0, 1, 1, 0, NOP, 0, 0, NOP, 0, 0),
                    ctl(0, 1, 0, 0, FWDSEL_ID_A)});
    s = st(BRANCH, 2, 0, 1, 1, 0, LOAD, 2, 1, IM_ALU, 2, 1);
    s.dc_wait = 1'b1;
    tbl.push_back('{"dcwait_top", s, ctl(1, 0, 0, 1, FWDSEL_ID_A)});

    // rst held throughout so each vector is evaluated from RUN.
    foreach (tbl[i]) begin
      s = tbl[i].in;
      s.rst = 1'b1;
      apply(s);
      #3;
      chk({tbl[i].name, ".tstall"},  32'(bus.stall),        32'(tbl[i].exp.stall));
      chk({tbl[i].name, ".tbubble"}, 32'(bus.id_ex_bubble), 32'(tbl[i].exp.bubble));
      chk({tbl[i].name, ".tflush"},  32'(bus.if_id_flush),  32'(tbl[i].exp.flush));
      chk({tbl[i].name, ".tfreeze"}, 32'(bus.pipe_freeze),  32'(tbl[i].exp.freeze));
      chk({tbl[i].name, ".tfwd"},    32'(bus.id_a_fwd_sel), 32'(tbl[i].exp.fwd));
      @(posedge clk);
      #1;
    end
    do_reset();

    // Load-use: one stall, then no forward from a load in MEM.
    do_cycle(st(RR_ALU, 3, 5, 0, 0, 0, LOAD, 3, 1, NOP, 0, 0), "lduse1");
    do_cycle(st(RR_ALU, 3, 5, 0, 0, 0, NOP, 0, 0, LOAD, 3, 1), "lduse2");
    chk("lduse.stall_cnt", bus.stall_cnt, 32'd1);

    // Branch after ALU producer: one stall, then forward and flush.
    do_cycle(st(BRANCH, 2, 0, 1, 0, 0, IM_ALU, 2, 1, NOP, 0, 0), "bralu1");
    do_cycle(st(BRANCH, 2, 0, 1, 0, 0, NOP, 0, 0, IM_ALU, 2, 1), "bralu2");
    chk("bralu.fwd", 32'(bus.id_a_fwd_sel), 32'(FWDSEL_EX_MEM_ALU_OUT));

    // Branch after load: two stalls.
    snap = bus.stall_cnt;
    do_cycle(st(BRANCH, 2, 0, 1, 0, 0, LOAD, 2, 1, NOP, 0, 0), "brld1");
    do_cycle(st(BRANCH, 2, 0, 1, 0, 0, NOP, 0, 0, LOAD, 2, 1), "brld2");
    do_cycle(st(BRANCH, 2, 0, 1, 0, 0, NOP, 0, 0, NOP, 0, 0), "brld3");
    chk("brld.stalls", bus.stall_cnt - snap, 32'd2);

    // Cache wait in RUN for 5 cycles.
    snap = bus.stall_cnt;
    s = nop_s();
    s.dc_wait = 1'b1;
    for (int i = 0; i < 5; i++) do_cycle(s, "dcrun");
    do_cycle(nop_s(), "dcrun_end");
    chk("dcrun.stalls", bus.stall_cnt - snap, 32'd5);

    // TRAP: halted after DRAIN+1 edges, then cycle_cnt frozen.
    do_reset();
    do_cycle(st(TRAP, 0, 0, 0, 1, 0, NOP, 0, 0, NOP, 0, 0), "trap");
    wait_halt(20, edges);
    chk("trap.edges", 32'(edges + 1), 32'(DRAIN + 1));
    chk("trap.illegal", 32'(bus.illegal_trap), 32'd0);
    snap = bus.cycle_cnt;
    do_cycle(nop_s(), "halted1");
    do_cycle(nop_s(), "halted2");
    chk("trap.cnt_frozen", bus.cycle_cnt, snap);

    // Reset while halted.
    do_reset();
    chk("rst.halted", 32'(bus.halted), 32'd0);
    chk("rst.cycles", bus.cycle_cnt, 32'd0);
    do_cycle(nop_s(), "post_rst");

    // Illegal instruction.
    do_cycle(st(RR_ALU, 0, 0, 0, 0, 1, NOP, 0, 0, NOP, 0, 0), "illegal");
    wait_halt(20, edges);
    chk("ill.edges", 32'(edges + 1), 32'(DRAIN + 1));
    chk("ill.flag", 32'(bus.illegal_trap), 32'd1);

    // Cache wait during DRAIN delays halt by exactly 5.
    do_reset();
    do_cycle(st(TRAP, 0, 0, 0, 1, 0, NOP, 0, 0, NOP, 0, 0), "trapdc");
    s = nop_s();
    s.dc_wait = 1'b1;
    for (int i = 0; i < 5; i++) do_cycle(s, "dcdrain");
    wait_halt(20, edges);
    chk("dcdrain.edges", 32'(edges + 6), 32'(DRAIN + 1 + 5));

    // Halt alongside a hazard is deferred one cycle.
    do_reset();
    do_cycle(st(RR_ALU, 3, 5, 0, 1, 0, LOAD, 3, 1, NOP, 0, 0), "halthz1");
    chk("halthz.no_accept", 32'(bus.id_ex_bubble), 32'd1);
    do_cycle(st(TRAP, 0, 0, 0, 1, 0, NOP, 0, 0, LOAD, 3, 1), "halthz2");
    wait_halt(20, edges);
    chk("halthz.edges", 32'(edges + 2), 32'(DRAIN + 2));

    // Random stream against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      s = st(opcode_class_e'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
             $urandom_range(0, 49) == 0, opcode_class_e'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             opcode_class_e'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1);
      s.dc_wait = $urandom_range(0, 5) == 0;
      s.rst     = $urandom_range(0, 39) == 0;
      do_cycle(s, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dlx_pipe_ctrl.md
# dlx_pipe_ctrl

Pipeline sequencer and hazard controller for the 5-stage DLX core. Watches the instruction in ID and the destination fields of ID/EX and EX/MEM, and drives the `stall`, bubble, flush and operand-A forward-select controls of the IF/ID/EX stages. Also sequences the orderly shutdown after TRAP or an illegal instruction, freezes the whole pipe on data-cache wait, and keeps cycle and stall counters. Sits beside `dlx_pipe_id`, between the IF, ID and EX pipe registers.

## Interface

Parameters
- `DRAIN_CYCLES`, default 3: cycles for in-flight EX/MEM/WB instructions to retire after halt is accepted (1..7).
- `CNT_W`, default 32: width of the performance counters.

Ports
- `clk` in 1: core clock.
- `rst` in 1: reset; synchronous, active-high. This is already decided and fixed.
- `dc_wait` in 1: data cache not ready; freezes the whole pipe.
- `id_opcode_class` in `opcode_class`: class of the instruction in ID.
- `id_ir_rs1`, `id_ir_rs2` in `reg_adr` (5 bits): source registers of the instruction in ID.
- `id_cond` in 1: branch taken or jump, resolved in ID.
- `id_halt` in 1: TRAP in ID.
- `id_illegal_instr` in 1: undecodable opcode in ID.
- `id_ex_opcode_class` in `opcode_class`, `id_ex_reg_rd` in 5 bits, `id_ex_reg_wen` in 1: producer currently in EX.
- `ex_mem_opcode_class` in `opcode_class`, `ex_mem_reg_rd` in 5 bits, `ex_mem_reg_wen` in 1: producer currently in MEM.
- `stall` out 1: hold PC and IF/ID.
- `id_ex_bubble` out 1: load a NOP (NOFORW, `reg_wen=0`, `dm_en=0`) into ID/EX.
- `if_id_flush` out 1: replace the IF/ID instruction with a NOP next edge.
- `pipe_freeze` out 1: hold every pipe register, including EX/MEM and MEM/WB.
- `id_a_fwd_sel` out `fwd_select`: `FWDSEL_EX_MEM_ALU_OUT` or `FWDSEL_ID_A`.
- `halted` out 1: pipe drained after TRAP or illegal instruction; sticky.
- `illegal_trap` out 1: halt cause was an illegal instruction; sticky.
- `cycle_cnt` out `CNT_W`: count of non-halted cycles.
- `stall_cnt` out `CNT_W`: count of cycles in which `stall` or `pipe_freeze` was 1.

## Operation

Definitions
- A register match requires a nonzero register. `uses_rs1` is true for RR_ALU, IM_ALU, LOAD, STORE and BRANCH. `uses_rs2` is true for RR_ALU and STORE.
- `ex_ld` = `id_ex_opcode_class==LOAD` && `id_ex_reg_wen` && rd matches a used source.
- `br_ex` = ID is BRANCH && `id_ex_reg_wen` && `id_ex_reg_rd==rs1`, for any class. The branch needs rs1 in ID, and EX is too late to forward.
- `br_mem_ld` = ID is BRANCH && `ex_mem` class is LOAD && `ex_mem_reg_wen` && `ex_mem_reg_rd==rs1`.
- `hazard` = `ex_ld` | `br_ex` | `br_mem_ld`.

Forwarding
- `id_a_fwd_sel` = `FWDSEL_EX_MEM_ALU_OUT` when `ex_mem_reg_wen`, `ex_mem_reg_rd==rs1`, rs1 is nonzero, and the EX/MEM class is RR_ALU or IM_ALU.
- Otherwise `id_a_fwd_sel` = `FWDSEL_ID_A`.

States
- RUN
  - `dc_wait`: `pipe_freeze`=1 and `stall`=1; all other outputs 0; go to DCWAIT.
  - Else if `hazard`: `stall`=1 and `id_ex_bubble`=1; `id_cond`, `id_halt` and `id_illegal_instr` are ignored this cycle.
  - Else if `id_halt` or `id_illegal_instr`: accept the instruction. Set `illegal_trap` = `id_illegal_instr`, load the drain counter with `DRAIN_CYCLES`, and go to DRAIN. The TRAP itself enters ID/EX as a bubble.
  - Else if `id_cond`: `if_id_flush`=1. No delay slot.
- DCWAIT
  - `pipe_freeze`=1 and `stall`=1 while `dc_wait` is 1.
  - When `dc_wait` falls, return to the state held before DCWAIT (RUN or DRAIN). The drain counter is frozen meanwhile.
- DRAIN
  - `stall`=1, `id_ex_bubble`=1, `if_id_flush`=1.
  - The counter decrements unless `dc_wait` is 1, in which case go to DCWAIT.
  - When the counter reaches 0, go to HALTED.
- HALTED
  - `halted`=1, `stall`=1, `pipe_freeze`=1, `id_ex_bubble`=1.
  - Held until `rst`.

Counters
- Both counters wrap modulo 2^`CNT_W`.
- Both are frozen in HALTED.

## Timing

- `stall`, `id_ex_bubble`, `if_id_flush`, `pipe_freeze` and `id_a_fwd_sel` are combinational from the current inputs and the registered state. They take effect at the next `clk` edge.
- `halted` and `illegal_trap` are registered.
- Reset (synchronous): state=RUN, counter=0, `halted`=0, `illegal_trap`=0, `cycle_cnt`=0, `stall_cnt`=0.
  - While `rst` is 1, the combinational outputs still evaluate normally.
  - `rst` mid-DRAIN or in HALTED returns to RUN on that edge.
- Latency
  - Load-use (`ex_ld`): 1 stall cycle.
  - Branch after ALU producer: 1 stall cycle, then forwarding.
  - Branch after load: 2 stall cycles.
  - Taken branch: 1 flushed slot.
  - TRAP: `halted` rises `DRAIN_CYCLES`+1 edges after the TRAP sits in ID, plus any DCWAIT cycles.
- Simultaneous events, in priority order: `dc_wait` > `hazard` > halt/illegal > `id_cond`.

## Test plan

- Load-use: `lw r3` in EX, then `add r4,r3,r5` in ID.
  - Expect exactly 1 cycle of `stall`=1 and `id_ex_bubble`=1, then `id_a_fwd_sel`=`FWDSEL_ID_A`, `stall_cnt`=1.
  - With `r0` as the destination, expect no stall.
- Branch hazards:
  - `addi r2` in EX, then `beqz r2` in ID: 1 stall, then `id_a_fwd_sel`=`FWDSEL_EX_MEM_ALU_OUT` with `id_cond` honoured and `if_id_flush`=1.
  - `lw r2` ahead of `beqz r2`: 2 stall cycles.
- TRAP:
  - `id_halt`=1 in RUN: `halted` rises 4 edges later (`DRAIN_CYCLES`=3) with `illegal_trap`=0; `cycle_cnt` then freezes.
  - Repeat with `id_illegal_instr`=1: expect `illegal_trap`=1.
- Cache wait:
  - `dc_wait` high for 5 cycles during RUN: `pipe_freeze`=1 for those 5 cycles, and `stall_cnt` increments by 5.
  - Repeat during DRAIN: `halted` is delayed by exactly 5 cycles.
- Priority: `id_cond`=1 and `ex_ld`=1 in the same cycle gives `stall`=1, `if_id_flush`=0. `id_halt` together with `hazard` defers the halt 1 cycle.
- Reset: assert `rst` one cycle while HALTED. Next cycle: `halted`=0, state RUN, counters 0, and a NOP in ID drives all controls to 0.
